// File: rtl/uba_intr_ack.sv
// uba_intr_ack
// WRU interrupt-acknowledge sequencer for one UBA. A WRU read selects the
// high (BR7/BR6) and/or low (BR5/BR4) device group by PI level, picks the
// highest-priority requesting device, holds ACK on it until it presents a
// vector or the ACK times out, then returns the vector to the read path.
module uba_intr_ack #(
    parameter int NDEV    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wruREAD,
    input  logic [2:0]           busPI,
    input  logic [2:0]           statPIH,
    input  logic [2:0]           statPIL,
    input  logic [NDEV-1:0]      devREQ,
    input  logic [2*NDEV-1:0]    devBR,
    input  logic [NDEV-1:0]      devVECTV,
    input  logic [16*NDEV-1:0]   devVECT,
    output logic [NDEV-1:0]      devACK,
    output logic                 wruBUSY,
    output logic                 wruDONE,
    output logic                 wruMATCH,
    output logic                 wruTIMEOUT,
    output logic [15:0]          wruVECT
);

    localparam int IDXW = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam int CNTW = 10;
    localparam logic [CNTW-1:0] TIMEOUT_C = CNTW'(TIMEOUT);

    // BR line codes as presented by the devices
    localparam logic [1:0] BR7 = 2'd3;
    localparam logic [1:0] BR6 = 2'd2;
    localparam logic [1:0] BR5 = 2'd1;
    localparam logic [1:0] BR4 = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] idx;
    } pick_t;

    // Lowest-index requesting device whose BR code equals the given level.
    function automatic pick_t pick_level(
        input logic [NDEV-1:0]   req,
        input logic [2*NDEV-1:0] br,
        input logic [1:0]        code
    );
        pick_t p;
        logic  hit;
        p.found = 1'b0;
        p.idx   = '0;
        // scan downward so the lowest index is the last writer
        for (int i = NDEV - 1; i >= 0; i--) begin
            hit     = req[i] && (br[2*i +: 2] == code);
            p.found = hit ? 1'b1 : p.found;
            p.idx   = hit ? IDXW'(i) : p.idx;
        end
        return p;
    endfunction

    // One-hot decode of a device index.
    function automatic logic [NDEV-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [NDEV-1:0] oh;
        for (int i = 0; i < NDEV; i++) begin
            oh[i] = (IDXW'(i) == idx);
        end
        return oh;
    endfunction

    state_t            state_q,   state_d;
    logic              match_h_q, match_h_d;
    logic              match_l_q, match_l_d;
    logic [IDXW-1:0]   sel_q,     sel_d;
    logic [CNTW-1:0]   cnt_q,     cnt_d;
    logic [NDEV-1:0]   dev_ack_q, dev_ack_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              match_q,   match_d;
    logic              tmo_q,     tmo_d;
    logic [15:0]       vect_q,    vect_d;

    pick_t             pick7_s, pick6_s, pick5_s, pick4_s;
    pick_t             win_s;
    logic              sel_valid_s;
    logic [15:0]       sel_vect_s;

    // Per-level candidates from the live request lines.
    always_comb begin
        pick7_s = pick_level(devREQ, devBR, BR7);
        pick6_s = pick_level(devREQ, devBR, BR6);
        pick5_s = pick_level(devREQ, devBR, BR5);
        pick4_s = pick_level(devREQ, devBR, BR4);
    end

    // Group priority: high group first when matched, low group as fallback.
    always_comb begin
        win_s = '0;
        if (match_h_q && pick7_s.found) begin
            win_s = pick7_s;
        end else if (match_h_q && pick6_s.found) begin
            win_s = pick6_s;
        end else if (match_l_q && pick5_s.found) begin
            win_s = pick5_s;
        end else if (match_l_q && pick4_s.found) begin
            win_s = pick4_s;
        end else begin
            win_s = '0;
        end
    end

    // Valid and vector of the currently acknowledged device only.
    always_comb begin
        sel_valid_s = devVECTV[sel_q];
        sel_vect_s  = devVECT[{sel_q, 4'b0000} +: 16];
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        match_h_d = match_h_q;
        match_l_d = match_l_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        dev_ack_d = dev_ack_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        match_d   = match_q;
        tmo_d     = tmo_q;
        vect_d    = vect_q;

        case (state_q)
            ST_IDLE: begin
                if (wruREAD) begin
                    match_h_d = (busPI != 3'd0) && (statPIH == busPI);
                    match_l_d = (busPI != 3'd0) && (statPIL == busPI);
                    busy_d    = 1'b1;
                    match_d   = 1'b0;
                    tmo_d     = 1'b0;
                    vect_d    = 16'h0000;
                    state_d   = ST_ARB;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (win_s.found) begin
                    sel_d     = win_s.idx;
                    cnt_d     = '0;
                    dev_ack_d = onehot(win_s.idx);
                    state_d   = ST_ACK;
                end else begin
                    match_d   = 1'b0;
                    vect_d    = 16'h0000;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_ACK: begin
                if (sel_valid_s) begin
                    vect_d    = sel_vect_s;
                    match_d   = 1'b1;
                    dev_ack_d = '0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == TIMEOUT_C) begin
                    tmo_d     = 1'b1;
                    match_d   = 1'b0;
                    vect_d    = 16'h0000;
                    dev_ack_d = '0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d     = cnt_q + 10'd1;
                end
            end
            ST_DONE: begin
                busy_d    = 1'b0;
                dev_ack_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                busy_d    = 1'b0;
                dev_ack_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops ACK immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            match_h_q <= 1'b0;
            match_l_q <= 1'b0;
            sel_q     <= '0;
            cnt_q     <= '0;
            dev_ack_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            tmo_q     <= 1'b0;
            vect_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            match_h_q <= match_h_d;
            match_l_q <= match_l_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            dev_ack_q <= dev_ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            match_q   <= match_d;
            tmo_q     <= tmo_d;
            vect_q    <= vect_d;
        end
    end

    assign devACK     = dev_ack_q;
    assign wruBUSY    = busy_q;
    assign wruDONE    = done_q;
    assign wruMATCH   = match_q;
    assign wruTIMEOUT = tmo_q;
    assign wruVECT    = vect_q;

endmodule

// File: tb/tb_uba_intr_ack.sv
// Bench for uba_intr_ack: directed vector table, hand-written reset and
// re-read sequences, and random transactions against a level-scan model.
module tb_uba_intr_ack;

    localparam int NDEV  = 4;
    localparam int TO    = 8;
    localparam int NEVER = 100;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               wru_read = 1'b0;
    logic [2:0]         bus_pi = 3'd0;
    logic [2:0]         stat_pih = 3'd0;
    logic [2:0]         stat_pil = 3'd0;
    logic [NDEV-1:0]    dev_req = '0;
    logic [2*NDEV-1:0]  dev_br = '0;
    logic [NDEV-1:0]    dev_vectv = '0;
    logic [16*NDEV-1:0] dev_vect = '0;
    logic [NDEV-1:0]    dev_ack;
    logic               wru_busy, wru_done, wru_match, wru_tmo;
    logic [15:0]        wru_vect;

    logic [15:0] devvec [NDEV];

    int n_chk  = 0;
    int n_fail = 0;

    uba_intr_ack #(.NDEV(NDEV), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .wruREAD(wru_read), .busPI(bus_pi),
        .statPIH(stat_pih), .statPIL(stat_pil), .devREQ(dev_req),
        .devBR(dev_br), .devVECTV(dev_vectv), .devVECT(dev_vect),
        .devACK(dev_ack), .wruBUSY(wru_busy), .wruDONE(wru_done),
        .wruMATCH(wru_match), .wruTIMEOUT(wru_tmo), .wruVECT(wru_vect)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  bp, pih, pil;
        logic [3:0]  req;
        logic [7:0]  br;
        int          dly;
        logic [3:0]  noise;
        logic [3:0]  exp_ack;
        int          exp_cyc;
        logic        exp_m, exp_t;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one WRU transaction starting #1 after a posedge; devices answer
    // dly cycles after they first see their ACK, others drive noise valids.
    task automatic run_txn(input logic [2:0] bp, pih, pil, input logic [3:0] req,
                           input logic [7:0] br, input int dly, input logic [3:0] noise,
                           input int extra_rd,
                           output logic [3:0] ack_seen, output int ack_cyc, output int ack_first,
                           output int done_cyc, output int done_cnt, output logic m,
                           output logic t, output logic [15:0] v,
                           output logic busy1, output logic busy_after);
        ack_seen = '0; ack_cyc = 0; ack_first = 0; done_cyc = -1; done_cnt = 0;
        m = 1'b0; t = 1'b0; v = 16'h0; busy1 = 1'b0; busy_after = 1'b1;
        bus_pi = bp; stat_pih = pih; stat_pil = pil; dev_req = req; dev_br = br;
        for (int i = 0; i < NDEV; i++) dev_vect[16*i +: 16] = devvec[i];
        dev_vectv = noise;
        wru_read = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            wru_read = (c == extra_rd);
            if (c == 1) busy1 = wru_busy;
            if (dev_ack != '0) begin
                if (ack_cyc == 0) ack_first = c;
                ack_seen = ack_seen | dev_ack;
                ack_cyc++;
            end
            if (wru_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c; m = wru_match; t = wru_tmo; v = wru_vect;
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after = wru_busy;
            for (int i = 0; i < NDEV; i++)
                dev_vectv[i] = dev_ack[i] ? ((c - ack_first) >= dly) : noise[i];
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        dev_req = '0; dev_vectv = '0; wru_read = 1'b0;
    endtask

    task automatic do_check(input string tag, input logic [2:0] bp, pih, pil,
                            input logic [3:0] req, input logic [7:0] br, input int dly,
                            input logic [3:0] noise, input int extra_rd,
                            input logic [3:0] e_ack, input int e_cyc,
                            input logic e_m, input logic e_t, input logic [15:0] e_v);
        logic [3:0] a; int ac, af, dc, dn; logic m, t, b1, ba; logic [15:0] v;
        run_txn(bp, pih, pil, req, br, dly, noise, extra_rd, a, ac, af, dc, dn, m, t, v, b1, ba);
        check({tag, " ack"},       32'(a),  32'(e_ack));
        check({tag, " ack_cyc"},   32'(ac), 32'(e_cyc));
        check({tag, " ack_rise"},  32'(af), (e_ack != '0) ? 32'd2 : 32'd0);
        check({tag, " done_cyc"},  32'(dc), 32'(2 + e_cyc));
        check({tag, " done_cnt"},  32'(dn), 32'd1);
        check({tag, " match"},     32'(m),  32'(e_m));
        check({tag, " timeout"},   32'(t),  32'(e_t));
        check({tag, " vect"},      32'(v),  32'(e_v));
        check({tag, " busy"},      32'(b1), 32'd1);
        check({tag, " busy_clr"},  32'(ba), 32'd0);
    endtask

    // Reference: try BR levels in group order, lowest index within a level.
    function automatic int model_winner(input logic [2:0] bp, pih, pil,
                                        input logic [3:0] req, input logic [7:0] br);
        int levels[$];
        if (bp != 3'd0 && pih == bp) begin levels.push_back(3); levels.push_back(2); end
        if (bp != 3'd0 && pil == bp) begin levels.push_back(1); levels.push_back(0); end
        foreach (levels[k])
            for (int i = 0; i < NDEV; i++)
                if (req[i] && int'(br[2*i +: 2]) == levels[k]) return i;
        return -1;
    endfunction

    vec_t tab [8];

    initial begin
        logic [3:0] mask, exp_ack;
        int w, cyc, r;

        devvec[0] = 16'o000060; devvec[1] = 16'o000254;
        devvec[2] = 16'o000300; devvec[3] = 16'o000410;

        //            bp    pih   pil   req      br           dly    noise    ack      cyc m     t
        tab[0] = '{3'd3, 3'd3, 3'd0, 4'b0010, 8'b00_00_10_00, 2,     4'b0000, 4'b0010, 3,  1'b1, 1'b0};
        tab[1] = '{3'd5, 3'd5, 3'd5, 4'b1101, 8'b11_11_00_00, 0,     4'b1001, 4'b0100, 1,  1'b1, 1'b0};
        tab[2] = '{3'd2, 3'd0, 3'd2, 4'b1111, 8'b10_10_10_10, 0,     4'b0000, 4'b0000, 0,  1'b0, 1'b0};
        tab[3] = '{3'd4, 3'd4, 3'd0, 4'b0001, 8'b00_00_00_11, NEVER, 4'b0000, 4'b0001, 9,  1'b0, 1'b1};
        tab[4] = '{3'd0, 3'd0, 3'd0, 4'b1111, 8'b11_11_11_11, 0,     4'b0000, 4'b0000, 0,  1'b0, 1'b0};
        tab[5] = '{3'd6, 3'd6, 3'd6, 4'b1010, 8'b00_11_01_11, 1,     4'b0101, 4'b0010, 2,  1'b1, 1'b0};
        tab[6] = '{3'd7, 3'd1, 3'd7, 4'b0110, 8'b00_00_11_00, 3,     4'b1011, 4'b0100, 4,  1'b1, 1'b0};
        tab[7] = '{3'd2, 3'd2, 3'd0, 4'b1100, 8'b10_10_00_00, 7,     4'b0000, 4'b0100, 8,  1'b1, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {12'd0, dev_ack, wru_busy, wru_done, wru_match, wru_tmo, wru_vect}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (tab[k]) begin
            w = -1;
            for (int i = 0; i < NDEV; i++) if (tab[k].exp_ack[i]) w = i;
            do_check($sformatf("vec%0d", k), tab[k].bp, tab[k].pih, tab[k].pil, tab[k].req,
                     tab[k].br, tab[k].dly, tab[k].noise, -1, tab[k].exp_ack, tab[k].exp_cyc,
                     tab[k].exp_m, tab[k].exp_t, (w >= 0 && tab[k].exp_m) ? devvec[w] : 16'h0);
            @(posedge clk); #1;
        end

        // second read during ACK is ignored
        do_check("reread", 3'd3, 3'd3, 3'd0, 4'b0010, 8'b00_00_10_00, 3, 4'b0000, 3,
                 4'b0010, 4, 1'b1, 1'b0, 16'o000254);
        @(posedge clk); #1;

        // reset during ACK
        bus_pi = 3'd4; stat_pih = 3'd4; stat_pil = 3'd0; dev_req = 4'b0001;
        dev_br = 8'b00_00_00_11; dev_vectv = '0; wru_read = 1'b1;
        @(posedge clk); #1; wru_read = 1'b0;
        @(posedge clk); #1;
        check("rst pre ack", 32'(dev_ack), 32'b0001);
        @(negedge clk); rst = 1'b0; #1;
        check("rst ack drop", 32'(dev_ack), 32'd0);
        check("rst busy", 32'(wru_busy), 32'd0);
        r = 0;
        repeat (2) begin @(posedge clk); #1; r += int'(wru_done); end
        rst = 1'b1; dev_req = '0;
        repeat (4) begin @(posedge clk); #1; r += int'(wru_done); end
        check("rst no done", 32'(r), 32'd0);
        do_check("post rst", 3'd3, 3'd3, 3'd0, 4'b0010, 8'b00_00_10_00, 2, 4'b0000, -1,
                 4'b0010, 3, 1'b1, 1'b0, 16'o000254);
        @(posedge clk); #1;

        // random transactions against the model
        for (int n = 0; n < 60; n++) begin
            logic [2:0] bp, pih, pil; logic [3:0] req, nz; logic [7:0] br; int dly;
            bp  = 3'($urandom_range(0, 7));
            pih = ($urandom_range(0, 1) == 0) ? bp : 3'($urandom_range(0, 7));
            pil = ($urandom_range(0, 1) == 0) ? bp : 3'($urandom_range(0, 7));
            req = 4'($urandom); br = 8'($urandom); nz = 4'($urandom);
            r   = $urandom_range(0, 9);
            dly = (r >= TO) ? NEVER : r;
            for (int i = 0; i < NDEV; i++) devvec[i] = 16'($urandom);
            w = model_winner(bp, pih, pil, req, br);
            mask = 4'b1111; exp_ack = '0; cyc = 0;
            if (w >= 0) begin
                mask[w] = 1'b0; exp_ack[w] = 1'b1;
                cyc = (dly < TO) ? dly + 1 : TO + 1;
            end
            do_check($sformatf("rnd%0d", n), bp, pih, pil, req, br, dly, nz & mask, -1,
                     exp_ack, cyc, (w >= 0 && dly < TO), (w >= 0 && dly >= TO),
                     (w >= 0 && dly < TO) ? devvec[w] : 16'h0);
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
